// File: rtl/link_ddr_downstream_sipo_token.sv
// ---------------------------------------------------------------------------
// link_ddr_downstream_sipo_token
// Receive-side stage of the DDR link: gathers num_pieces_p channel pieces into
// one core word, buffers finished words in a small FIFO, and returns credit to
// the sender as a token that toggles once per 2^lg_credit_decimation_p pops.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   io_valid_i/io_data_i : incoming link piece (piece 0 is least significant)
//   core_valid_o         : FIFO head valid
//   core_data_o          : FIFO head word (0 when empty)
//   core_yumi_i          : core consumes head word this cycle
//   token_o              : credit token level
//   overflow_o           : sticky, a completed word was dropped on a full FIFO
//   words_consumed_o     : consumed-word residue counter
// ---------------------------------------------------------------------------
module link_ddr_downstream_sipo_token #(
   parameter int unsigned channel_width_p        = 8,
   parameter int unsigned num_pieces_p           = 8,
   parameter int unsigned fifo_els_p             = 4,
   parameter int unsigned lg_credit_decimation_p = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      io_valid_i,
   input  logic [channel_width_p-1:0]                io_data_i,
   output logic                                      core_valid_o,
   output logic [channel_width_p*num_pieces_p-1:0]   core_data_o,
   input  logic                                      core_yumi_i,
   output logic                                      token_o,
   output logic                                      overflow_o,
   output logic [lg_credit_decimation_p-1:0]         words_consumed_o
);

   localparam int unsigned CoreWidth = channel_width_p * num_pieces_p;
   localparam int unsigned CntWidth  = (num_pieces_p > 1) ? $clog2(num_pieces_p) : 1;
   localparam int unsigned PtrWidth  = $clog2(fifo_els_p);
   localparam int unsigned OccWidth  = PtrWidth + 1;

   logic [CntWidth-1:0]               r_piece_cnt;
   logic [CoreWidth-1:0]              r_assembly;
   logic [CoreWidth-1:0]              r_mem [fifo_els_p];
   logic [PtrWidth-1:0]               r_rd_ptr;
   logic [PtrWidth-1:0]               r_wr_ptr;
   logic [OccWidth-1:0]               r_occ;
   logic                              r_valid;
   logic                              r_token;
   logic                              r_overflow;
   logic [lg_credit_decimation_p-1:0] r_words_consumed;

   logic [CoreWidth-1:0]              w_asm_next;
   logic                              w_last;
   logic                              w_full;
   logic                              w_pop;
   logic                              w_push;
   logic                              w_drop;
   logic [OccWidth-1:0]               w_occ_next;

   // Assembly register with the current piece merged in; on the last piece
   // this is the completed word that gets pushed on the same edge.
   always_comb begin
      w_asm_next = r_assembly;
      for (int unsigned i = 0; i < num_pieces_p; i++) begin
         if (io_valid_i && (r_piece_cnt == CntWidth'(i))) begin
            w_asm_next[i*channel_width_p +: channel_width_p] = io_data_i;
         end
      end
   end

   // FIFO control; a pop in the completion cycle frees the slot for the push.
   always_comb begin
      w_last = io_valid_i && (r_piece_cnt == CntWidth'(num_pieces_p - 1));
      w_full = (r_occ == OccWidth'(fifo_els_p));
      w_pop  = core_yumi_i && r_valid;
      w_push = w_last && (!w_full || w_pop);
      w_drop = w_last && w_full && !w_pop;
      w_occ_next = r_occ;
      if (w_push && !w_pop) begin
         w_occ_next = r_occ + OccWidth'(1);
      end else if (!w_push && w_pop) begin
         w_occ_next = r_occ - OccWidth'(1);
      end
   end

   // Piece counter and assembly register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_piece_cnt <= '0;
         r_assembly  <= '0;
      end else if (io_valid_i) begin
         r_assembly  <= w_asm_next;
         r_piece_cnt <= w_last ? '0 : r_piece_cnt + CntWidth'(1);
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < fifo_els_p; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_occ    <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_asm_next;
            r_wr_ptr        <= r_wr_ptr + PtrWidth'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
         end
         r_occ   <= w_occ_next;
         r_valid <= (w_occ_next != '0);
      end
   end

   // Credit return and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_words_consumed <= '0;
         r_token          <= 1'b0;
         r_overflow       <= 1'b0;
      end else begin
         if (w_pop) begin
            r_words_consumed <= r_words_consumed + lg_credit_decimation_p'(1);
            if (r_words_consumed == '1) begin
               r_token <= ~r_token;
            end
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign core_valid_o     = r_valid;
   assign core_data_o      = r_valid ? r_mem[r_rd_ptr] : '0;
   assign token_o          = r_token;
   assign overflow_o       = r_overflow;
   assign words_consumed_o = r_words_consumed;

endmodule

// File: doc/link_ddr_downstream_sipo_token.md
Name: link_ddr_downstream_sipo_token

Overview:
- Receive-side stage that consumes the per-channel byte stream the upstream DDR link serializer emits.
- Reassembles `num_pieces_p` consecutive channel pieces into one core word and buffers completed words in a small FIFO for the core.
- Returns flow-control credit to the upstream sender as a toggling token, one toggle per 2^`lg_credit_decimation_p` words consumed by the core.
- Single-clock version of the downstream half used for composition checks against the upstream token-in model.

Parameters:
- `channel_width_p`, 8: width of one link piece.
- `num_pieces_p`, 8: pieces per core word; core word width = `channel_width_p` * `num_pieces_p` = 64.
- `fifo_els_p`, 4: depth of the completed-word FIFO; power of two, ≥2.
- `lg_credit_decimation_p`, 3: log2 of the number of consumed words per token toggle.

Ports:
- `clk`, in, 1: the one clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `io_valid_i`, in, 1: a link piece is present this cycle.
- `io_data_i`, in, `channel_width_p`: link piece.
- `core_valid_o`, out, 1: FIFO head word valid.
- `core_data_o`, out, `channel_width_p`*`num_pieces_p`: FIFO head word.
- `core_yumi_i`, in, 1: core consumes the head word this cycle.
- `token_o`, out, 1: credit token level; each toggle returns 2^`lg_credit_decimation_p` credits.
- `overflow_o`, out, 1: sticky error, a completed word arrived while the FIFO was full with no pop.
- `words_consumed_o`, out, `lg_credit_decimation_p`: consumed-word counter toggled against, for observation.

Behaviour:
- Reset (async assert, sync-release semantics in the bench):
  - piece counter = 0; assembly register = 0.
  - FIFO empty: `core_valid_o` = 0, `core_data_o` = 0.
  - `token_o` = 0, `overflow_o` = 0, `words_consumed_o` = 0.
- Assembly:
  - On each `clk` edge with `io_valid_i` = 1, store the piece at bits [k*`channel_width_p` +: `channel_width_p`], where k is the piece counter. Piece 0 is the least significant.
  - k then increments, wrapping from `num_pieces_p`-1 to 0.
  - `io_valid_i` = 0 holds all assembly state.
- Word completion:
  - When k = `num_pieces_p`-1 and `io_valid_i` = 1, the full word (the last piece merged combinationally) is pushed into the FIFO on that edge.
  - Latency: `core_valid_o` rises in the cycle after the edge that captured the last piece.
- FIFO:
  - `core_data_o` shows the head word; it is 0 when empty.
  - Pop occurs when `core_yumi_i` & `core_valid_o`; `core_yumi_i` while empty is ignored and changes no state.
  - Push and pop in the same cycle are both honoured, including when full: occupancy is unchanged and no overflow is flagged.
  - Empty with a simultaneous push and yumi: the yumi is ignored because `core_valid_o` was 0, and the word lands.
  - Occupancy counter is `clog2(fifo_els_p)`+1 bits; read and write pointers wrap modulo `fifo_els_p`.
- Overflow:
  - A word completes while occupancy = `fifo_els_p` and no pop occurs in that cycle.
  - The word is dropped, `overflow_o` is set the next cycle and stays set until `rst`.
  - FIFO contents are unaffected.
- Credit return:
  - Every pop increments `words_consumed_o`, modulo 2^`lg_credit_decimation_p`.
  - On a pop that wraps it from all-ones to 0, `token_o` toggles on the same edge.
  - Pushes never affect credits.
- Reset mid-operation:
  - Any partially assembled word, all FIFO contents and the credit residue are discarded immediately on `rst` assertion.
  - Nothing is emitted until `num_pieces_p` new pieces arrive after release.
- All outputs are registered except `core_data_o`, which is a FIFO read mux of registered storage.

Test Plan:
- Single word: feed pieces 0x11,0x22,...,0x88 on 8 consecutive cycles, `core_yumi_i` = 0 → `core_valid_o` = 1 from cycle 9, `core_data_o` = 0x8877665544332211, `token_o` stays 0.
- Gapped input: the same 8 pieces with `io_valid_i` low on alternate cycles → identical word, `core_valid_o` rises one cycle after the 8th valid piece.
- Credit toggle: stream 8 words, yumi each as soon as valid → `words_consumed_o` steps 1..7,0; `token_o` toggles 0→1 exactly on the 8th pop. 16 words → back to 0.
- Full FIFO:
  - Fill 4 words with no yumi, then complete a 5th with no yumi → `overflow_o` = 1 next cycle, FIFO still holds words 1–4 in order.
  - Repeat with yumi asserted on the 5th word's completion cycle → `overflow_o` stays 0, head becomes word 2, word 5 queued.
- Yumi while empty: assert `core_yumi_i` with the FIFO empty for 3 cycles → no pop, `words_consumed_o` = 0, no token toggle.
- Reset mid-word: feed 5 pieces, pulse `rst`, then 8 fresh pieces 0xA0..0xA7 → single word 0xA7A6A5A4A3A2A1A0, no stale bytes, all counters restarted.
